// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width and Gray/binary pointer conversions,
// used by both the read-side empty block and the write-side full block.
package fifo_pkg;

  localparam int ADDRSIZE = 8;
  localparam int PTR_W    = ADDRSIZE + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin[PTR_W-1] = gray[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rptr_empty.sv
// Read-domain pointer and status stage of the async FIFO: binary/Gray read pointer,
// registered empty, almost-empty, occupancy level and sticky underflow.
module fifo_rptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE  = fifo_pkg::ADDRSIZE,
  parameter int AE_THRESH = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic                rclr_err,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AE_LIMIT = PW'(AE_THRESH);

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] level_next;
  logic              rd_ok;
  logic              rd_bad;

  always_comb begin
    rd_ok      = rinc & ~rempty;
    rd_bad     = rinc & rempty;
    rbinnext   = rbin + PW'(rd_ok);
    rgraynext  = bin2gray(rbinnext);
    wbin       = gray2bin(rq2_wptr);
    // Stale write pointer makes this an underestimate, never an overestimate.
    level_next = wbin - rbinnext;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
      runderflow    <= 1'b0;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      // Full-width Gray compare, MSB included, so a full FIFO is not mistaken for empty.
      rempty        <= (rgraynext == rq2_wptr);
      ralmost_empty <= (level_next <= AE_LIMIT);
      rlevel        <= level_next;
      if (rd_bad)
        runderflow <= 1'b1;
      else if (rclr_err)
        runderflow <= 1'b0;
    end
  end

  assign raddr = rbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Randomised self-checking bench for fifo_rptr_empty against a read/write-count model.
module tb_fifo_rptr_empty;

  localparam int AS    = 8;
  localparam int DEPTH = 1 << AS;
  localparam int MOD   = 2 * DEPTH;
  localparam int AE    = 4;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rinc;
  logic          rclr_err;
  logic [AS:0]   rq2_wptr;
  logic [AS-1:0] raddr;
  logic [AS:0]   rptr;
  logic          rempty;
  logic          ralmost_empty;
  logic [AS:0]   rlevel;
  logic          runderflow;

  fifo_rptr_empty #(.ADDRSIZE(AS), .AE_THRESH(AE)) dut (
    .rclk         (rclk),
    .rrst         (rrst),
    .rinc         (rinc),
    .rclr_err     (rclr_err),
    .rq2_wptr     (rq2_wptr),
    .raddr        (raddr),
    .rptr         (rptr),
    .rempty       (rempty),
    .ralmost_empty(ralmost_empty),
    .rlevel       (rlevel),
    .runderflow   (runderflow)
  );

  always #5 rclk = ~rclk;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: total reads accepted and total writes made visible, as plain integers.
  int m_rd    = 0;
  int m_wr    = 0;
  int m_level = 0;
  bit m_empty = 1'b1;
  bit m_uf    = 1'b0;

  function automatic int gray_of(input int n);
    int b;
    b = n % MOD;
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("raddr",         int'(raddr),         m_rd % DEPTH);
    check("rptr",          int'(rptr),          gray_of(m_rd));
    check("rempty",        int'(rempty),        int'(m_empty));
    check("ralmost_empty", int'(ralmost_empty), int'(m_level <= AE));
    check("rlevel",        int'(rlevel),        m_level);
    check("runderflow",    int'(runderflow),    int'(m_uf));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input bit rst, input bit inc, input bit clr, input int wr);
    bit ok;
    rrst     = rst;
    rinc     = inc;
    rclr_err = clr;
    m_wr     = wr;
    rq2_wptr = (AS+1)'(gray_of(wr));
    @(posedge rclk);
    if (rst) begin
      m_rd = 0; m_level = 0; m_empty = 1'b1; m_uf = 1'b0;
    end else begin
      ok = inc && !m_empty;
      if (inc && m_empty) m_uf = 1'b1;
      else if (clr)       m_uf = 1'b0;
      m_rd    = m_rd + int'(ok);
      m_level = m_wr - m_rd;
      m_empty = (m_level == 0);
    end
    #1;
    compare_all();
  endtask

  initial begin
    int wr;
    rrst = 1'b0; rinc = 1'b0; rclr_err = 1'b0; rq2_wptr = '0;

    // Reset state
    step(1, 0, 0, 0);
    check("rst_rempty", int'(rempty), 1);
    check("rst_ae",     int'(ralmost_empty), 1);
    check("rst_level",  int'(rlevel), 0);
    check("rst_rptr",   int'(rptr), 0);

    // Three entries, read them out
    step(0, 0, 0, 3);
    check("t2_empty", int'(rempty), 0);
    check("t2_level", int'(rlevel), 3);
    step(0, 1, 0, 3);
    check("t2_rptr1", int'(rptr), 'h001);
    step(0, 1, 0, 3);
    check("t2_rptr2", int'(rptr), 'h003);
    step(0, 1, 0, 3);
    check("t2_rptr3", int'(rptr), 'h002);
    check("t2_raddr3", int'(raddr), 3);
    check("t2_empty3", int'(rempty), 1);

    // Underflow set, clear, set-wins-over-clear
    step(0, 1, 0, 3);
    check("t3_uf_set", int'(runderflow), 1);
    check("t3_raddr",  int'(raddr), 3);
    step(0, 0, 1, 3);
    check("t3_uf_clr", int'(runderflow), 0);
    step(0, 1, 1, 3);
    check("t3_uf_win", int'(runderflow), 1);

    // Full FIFO and wrap-around
    step(1, 0, 0, 0);
    step(0, 0, 0, 256);
    check("t4_level_full", int'(rlevel), 256);
    check("t4_empty_full", int'(rempty), 0);
    check("t4_ae_full",    int'(ralmost_empty), 0);
    for (int i = 0; i < 256; i++) step(0, 1, 0, 256);
    check("t4_raddr_wrap", int'(raddr), 0);
    check("t4_rptr_wrap",  int'(rptr), 'h180);
    check("t4_empty_wrap", int'(rempty), 1);
    step(0, 0, 0, 257);
    step(0, 1, 0, 257);
    check("t4_rptr_257",  int'(rptr), 'h181);
    check("t4_empty_257", int'(rempty), 1);

    // Almost-empty threshold
    step(0, 0, 0, 262);
    check("t5_level5", int'(rlevel), 5);
    check("t5_ae5",    int'(ralmost_empty), 0);
    step(0, 1, 0, 262);
    check("t5_level4", int'(rlevel), 4);
    check("t5_ae4",    int'(ralmost_empty), 1);

    // Reset mid-stream, then a reset glitch between edges
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 8);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8);
    check("t6_raddr5", int'(raddr), 5);
    check("t6_uf",     int'(runderflow), 1);
    step(1, 1, 0, 8);
    check("t6_rst_level", int'(rlevel), 0);
    check("t6_rst_raddr", int'(raddr), 0);
    check("t6_rst_uf",    int'(runderflow), 0);
    step(0, 0, 0, 2);
    #1 rrst = 1'b1;
    #2 rrst = 1'b0;
    step(0, 0, 0, 2);
    check("t6_glitch_level", int'(rlevel), 2);

    // Random traffic with occasional reset
    step(1, 0, 0, 0);
    wr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        wr = 0;
        step(1, $urandom_range(0, 1) == 1, 0, 0);
      end else begin
        wr = wr + int'($urandom_range(0, 2));
        if (wr - m_rd > DEPTH) wr = m_rd + DEPTH;
        step(0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, wr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
